// File: rtl/counter_checker.sv
// counter_checker: predicts each next counter value from the observed controls and count,
// flags mismatches, and keeps a sticky flag, saturating counters and a first-error capture.
module counter_checker #(
    parameter int COUNT_WIDTH   = 3,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int CYC_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dut_reset_,
    input  logic                     chk_enable,
    input  logic                     err_clear,
    input  logic                     load_,
    input  logic [COUNT_WIDTH-1:0]   load_val,
    input  logic                     count_enable_,
    input  logic                     count_dir,
    input  logic [1:0]               count_type,
    input  logic [COUNT_WIDTH-1:0]   count,
    output logic                     err_pulse,
    output logic                     err_flag,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [COUNT_WIDTH-1:0]   err_exp,
    output logic [COUNT_WIDTH-1:0]   err_got,
    output logic [CYC_CNT_WIDTH-1:0] chk_cycles,
    output logic                     chk_active
);
    localparam int W = COUNT_WIDTH;

    typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

    state_t                   state_q, state_d;
    logic [W-1:0]             exp_q, exp_d, step, bin, bin_n, gray_n;
    logic [W-1:0]             err_exp_q, err_exp_d, err_got_q, err_got_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d, err_base;
    logic [CYC_CNT_WIDTH-1:0] cyc_q, cyc_d, cyc_base;
    logic                     err_pulse_q, err_flag_q, err_flag_d, cmp, mis, capture;

    for (genvar g = 0; g < W; g++) begin : g_g2b
        assign bin[g] = ^(count >> g);
    end

    assign bin_n  = count_dir ? bin + 1'b1 : bin - 1'b1;
    assign gray_n = bin_n ^ (bin_n >> 1);
    assign step   = count_type == 2'd0 ? (count_dir ? count + 1'b1 : count - 1'b1)
                  : count_type == 2'd1 ? gray_n
                  : count_type == 2'd2 ? (count_dir ? {~count[0], count[W-1:1]} : {count[W-2:0], ~count[W-1]})
                  : (count_dir ? {count[0], count[W-1:1]} : {count[W-2:0], count[W-1]});
    // The prediction is always based on the observed count so a single fault resyncs next cycle
    assign exp_d  = !dut_reset_ ? '0 : !load_ ? load_val : count_enable_ ? count : step;

    always_comb begin
        state_d = !chk_enable ? IDLE : state_q == IDLE ? SYNC : CHECK;
    end

    assign cmp         = state_q == CHECK && chk_enable;
    assign mis         = cmp && (count !== exp_q);
    assign err_base    = err_clear ? '0 : err_count_q;
    assign cyc_base    = err_clear ? '0 : cyc_q;
    assign capture     = mis && (err_clear || !err_flag_q);
    assign err_count_d = mis && !(&err_base) ? err_base + 1'b1 : err_base;
    assign cyc_d       = cmp && !(&cyc_base) ? cyc_base + 1'b1 : cyc_base;
    assign err_flag_d  = mis || (err_flag_q && !err_clear);
    assign err_exp_d   = capture ? exp_q : err_clear ? '0 : err_exp_q;
    assign err_got_d   = capture ? count : err_clear ? '0 : err_got_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            err_pulse_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            err_pulse_q <= mis;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
            cyc_q       <= cyc_d;
        end
    end

    assign err_pulse  = err_pulse_q;
    assign err_flag   = err_flag_q;
    assign err_count  = err_count_q;
    assign err_exp    = err_exp_q;
    assign err_got    = err_got_q;
    assign chk_cycles = cyc_q;
    assign chk_active = state_q == CHECK;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed spec sequences plus randomized traffic against a behavioural model.
module tb_counter_checker;
    localparam int W = 3;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic reset, dut_reset_, chk_enable, err_clear, load_, count_enable_, count_dir;
    logic [W-1:0] load_val, count;
    logic [1:0] count_type;
    logic err_pulse, err_flag, chk_active, p2, f2, a2;
    logic [7:0] err_count;
    logic [1:0] c2;
    logic [W-1:0] err_exp, err_got, e2, g2;
    logic [15:0] chk_cycles, y2;

    int errors = 0, checks = 0;
    int m_exp, m_nen, m_cnt, m_cnt2, m_eexp, m_egot, m_cyc;
    bit m_pulse, m_flag;
    int np, first;

    always #5 clk = ~clk;

    counter_checker dut (
        .clk(clk), .reset(reset), .dut_reset_(dut_reset_), .chk_enable(chk_enable),
        .err_clear(err_clear), .load_(load_), .load_val(load_val), .count_enable_(count_enable_),
        .count_dir(count_dir), .count_type(count_type), .count(count), .err_pulse(err_pulse),
        .err_flag(err_flag), .err_count(err_count), .err_exp(err_exp), .err_got(err_got),
        .chk_cycles(chk_cycles), .chk_active(chk_active)
    );

    counter_checker #(.ERR_CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .dut_reset_(dut_reset_), .chk_enable(chk_enable),
        .err_clear(err_clear), .load_(load_), .load_val(load_val), .count_enable_(count_enable_),
        .count_dir(count_dir), .count_type(count_type), .count(count), .err_pulse(p2),
        .err_flag(f2), .err_count(c2), .err_exp(e2), .err_got(g2),
        .chk_cycles(y2), .chk_active(a2)
    );

    // Next counter value from the counting rules, phrased as integer arithmetic
    function automatic int pred(int c);
        int i, j;
        i = 0;
        if (!dut_reset_) return 0;
        if (!load_) return int'(load_val);
        if (count_enable_) return c;
        case (count_type)
            2'd0: return (c + (count_dir ? 1 : M - 1)) % M;
            2'd1: begin
                for (int k = 0; k < M; k++) if ((k ^ (k >> 1)) == c) i = k;
                j = (i + (count_dir ? 1 : M - 1)) % M;
                return j ^ (j >> 1);
            end
            2'd2: return count_dir ? (c >> 1) | ((1 - (c & 1)) << (W - 1))
                                   : ((c << 1) % M) | (1 - ((c >> (W - 1)) & 1));
            default: return count_dir ? (c >> 1) | ((c & 1) << (W - 1))
                                      : ((c << 1) % M) | ((c >> (W - 1)) & 1);
        endcase
    endfunction

    task automatic tick();
        bit cmp, mis;
        @(posedge clk);
        if (reset) begin
            {m_pulse, m_flag} = '0;
            {m_exp, m_nen, m_cnt, m_cnt2, m_eexp, m_egot, m_cyc} = '0;
        end else begin
            cmp = chk_enable && m_nen >= 2;
            mis = cmp && (int'(count) != m_exp);
            if (err_clear) begin
                m_flag = 0;
                {m_cnt, m_cnt2, m_eexp, m_egot, m_cyc} = '0;
            end
            if (cmp && m_cyc < 65535) m_cyc++;
            if (mis) begin
                if (!m_flag) begin
                    m_eexp = m_exp;
                    m_egot = int'(count);
                end
                m_flag = 1;
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_pulse = mis;
            m_nen = chk_enable ? (m_nen < 2 ? m_nen + 1 : 2) : 0;
            m_exp = pred(int'(count));
        end
        #1;
    endtask

    task automatic run_seq(input int ty, input int dir, input int lv, input logic [17:0] seq,
                           input int n, output int npulse, output int firstp);
        reset = 0; dut_reset_ = 1; chk_enable = 0; err_clear = 1; load_ = 1; count_enable_ = 1;
        tick();
        err_clear = 0; chk_enable = 1; load_ = 0; load_val = W'(lv);
        tick();
        load_ = 1; count_enable_ = 0; count_type = 2'(ty); count_dir = 1'(dir); count = W'(lv);
        tick();
        npulse = 0; firstp = -1;
        for (int i = 0; i < n; i++) begin
            count = seq[3*i +: 3];
            tick();
            if (err_pulse) begin
                npulse++;
                if (firstp < 0) firstp = i;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1; count = 3'd5;
        tick(); tick();
        checks++; if ({err_pulse, err_flag, err_count, err_exp, err_got, chk_cycles, chk_active} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {err_pulse, err_flag, err_count, err_exp, err_got, chk_cycles, chk_active});
        end
        checks++; if ({p2, f2, c2, e2, g2, y2, a2} !== '0) begin
            errors++; $display("FAIL reset_outputs_w2: got %h want 0", {p2, f2, c2, e2, g2, y2, a2});
        end
        reset = 0;
    endtask

    task automatic test_bin_wrap();
        run_seq(0, 1, 6, {3'd0, 3'd0, 3'd2, 3'd1, 3'd0, 3'd7}, 4, np, first);
        checks++; if (err_count !== 8'd0 || err_flag !== 1'b0 || np != 0) begin
            errors++; $display("FAIL bin_wrap_errors: got cnt=%0d flag=%0b pulses=%0d want 0 0 0", err_count, err_flag, np);
        end
        checks++; if (chk_cycles !== 16'd4 || chk_active !== 1'b1) begin
            errors++; $display("FAIL bin_wrap_cycles: got %0d active=%0b want 4 1", chk_cycles, chk_active);
        end
    endtask

    task automatic test_gray();
        run_seq(1, 1, 5, {3'd0, 3'd0, 3'd3, 3'd1, 3'd0, 3'd4}, 4, np, first);
        checks++; if (err_flag !== 1'b0 || np != 0 || chk_cycles !== 16'd4) begin
            errors++; $display("FAIL gray_up: got flag=%0b pulses=%0d cyc=%0d want 0 0 4", err_flag, np, chk_cycles);
        end
    endtask

    task automatic test_fault();
        run_seq(0, 1, 0, {3'd0, 3'd0, 3'd5, 3'd4, 3'd3, 3'd1}, 4, np, first);
        checks++; if (np != 1 || first != 1) begin
            errors++; $display("FAIL fault_pulse: got pulses=%0d at=%0d want 1 at 1", np, first);
        end
        checks++; if (err_exp !== 3'd2 || err_got !== 3'd3) begin
            errors++; $display("FAIL fault_capture: got exp=%0d got=%0d want 2 3", err_exp, err_got);
        end
        checks++; if (err_count !== 8'd1 || err_flag !== 1'b1) begin
            errors++; $display("FAIL fault_count: got cnt=%0d flag=%0b want 1 1", err_count, err_flag);
        end
    endtask

    task automatic test_johnson();
        run_seq(2, 0, 0, {3'd0, 3'd0, 3'd6, 3'd7, 3'd3, 3'd1}, 4, np, first);
        checks++; if (np != 0 || err_flag !== 1'b0) begin
            errors++; $display("FAIL johnson_down: got pulses=%0d flag=%0b want 0 0", np, err_flag);
        end
        load_ = 0; load_val = 3'd5; count = 3'd4;
        tick();
        load_ = 1; count = 3'd5;
        tick();
        checks++; if (err_count !== 8'd0 || chk_cycles !== 16'd6 || err_pulse !== 1'b0) begin
            errors++; $display("FAIL load_priority: got cnt=%0d cyc=%0d pulse=%0b want 0 6 0", err_count, chk_cycles, err_pulse);
        end
    endtask

    task automatic test_saturation();
        run_seq(0, 1, 0, {3'd0, 3'd2, 3'd3, 3'd0, 3'd6, 3'd3}, 5, np, first);
        checks++; if (c2 !== 2'd3 || err_count !== 8'd5 || np != 5) begin
            errors++; $display("FAIL saturation: got w2=%0d w8=%0d pulses=%0d want 3 5 5", c2, err_count, np);
        end
        checks++; if (e2 !== 3'd1 || g2 !== 3'd3) begin
            errors++; $display("FAIL saturation_capture: got exp=%0d got=%0d want 1 3", e2, g2);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1; count = 3'd7;
        tick();
        checks++; if ({err_pulse, err_flag, err_count, err_exp, err_got, chk_cycles, chk_active, c2} !== '0) begin
            errors++; $display("FAIL reset_mid: got %h want 0", {err_pulse, err_flag, err_count, err_exp, err_got, chk_cycles, chk_active, c2});
        end
        reset = 0;
        run_seq(0, 1, 0, {3'd0, 3'd0, 3'd0, 3'd5, 3'd4, 3'd3}, 3, np, first);
        count = 3'd0; err_clear = 1;
        tick();
        err_clear = 0;
        checks++; if (err_count !== 8'd1 || err_flag !== 1'b1 || err_pulse !== 1'b1 || c2 !== 2'd1) begin
            errors++; $display("FAIL clear_with_fault: got cnt=%0d flag=%0b pulse=%0b w2=%0d want 1 1 1 1", err_count, err_flag, err_pulse, c2);
        end
        checks++; if (err_exp !== 3'd6 || err_got !== 3'd0) begin
            errors++; $display("FAIL clear_capture: got exp=%0d got=%0d want 6 0", err_exp, err_got);
        end
    endtask

    task automatic test_random();
        int nxt;
        logic [33:0] want;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom % 64) == 0;
            dut_reset_ = ($urandom % 16) != 0;
            chk_enable = ($urandom % 32) != 0;
            err_clear = ($urandom % 40) == 0;
            load_ = ($urandom % 8) != 0;
            load_val = W'($urandom);
            count_enable_ = ($urandom % 5) == 0;
            count_dir = 1'($urandom);
            count_type = 2'($urandom);
            nxt = pred(int'(count));
            tick();
            want = {m_pulse, m_flag, 8'(m_cnt), 3'(m_eexp), 3'(m_egot), 16'(m_cyc), m_nen >= 2};
            checks++; if ({err_pulse, err_flag, err_count, err_exp, err_got, chk_cycles, chk_active} !== want || c2 !== 2'(m_cnt2)) begin
                errors++; $display("FAIL random[%0d]: got %h w2=%0d want %h w2=%0d", i,
                    {err_pulse, err_flag, err_count, err_exp, err_got, chk_cycles, chk_active}, c2, want, m_cnt2);
            end
            count = ($urandom % 10) == 0 ? W'($urandom) : W'(nxt);
        end
    endtask

    initial begin
        reset = 1; dut_reset_ = 1; chk_enable = 0; err_clear = 0; load_ = 1; load_val = '0;
        count_enable_ = 1; count_dir = 1; count_type = 2'd0; count = '0;
        test_reset();
        test_bin_wrap();
        test_gray();
        test_fault();
        test_johnson();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
